skipdecode: RTL and testbench
=============================

# skipdecode

Receive-side companion to the clock-skip ring. Observes, once per `iCLK` cycle, whether the gated clock produced a pulse or swallowed it. It recovers the periodic skip mask, aligned so that bit 0 is the first skip seen, then locks to it and flags any departure from the learned pattern. It sits in the `iCLK` domain next to the skip ring and feeds status logic and verification monitors.

## Interface
- `LEN`, 16: ring length and mask width, ≥2.
- `CONFIRM`, 2: consecutive identical periods required to lock, ≥2.
- `iCLK` in 1: single clock. All logic acts on the posedge.
- `iRSTN` in 1: reset, synchronous and active-low.
- `iE` in 1: decoder enable.
- `iPULSE` in 1: 1 means this `iCLK` cycle passed a gated pulse; 0 means the pulse was swallowed (a skip).
- `oMASK` out LEN: learned skip mask. Bit *i* is set when a skip occurs at phase *i*.
- `oLOCK` out 1: mask learned and tracking.
- `oVALID` out 1: one-cycle strobe when `oMASK` is updated.
- `oERR` out 1: one-cycle strobe on a mismatch while locked.
- `oSKIPS` out clog2(LEN+1): popcount of `oMASK`.
- `oERRCNT` out 8: saturating mismatch count. Present only with the macro described under Configuration.

## Operation
- **States:** IDLE, SEEK, TRACK, LOCK.
- **Phase counter:** clog2(LEN) bits, counts 0..LEN-1 and wraps to 0.
- **Reset** (`iRSTN`=0 at a posedge):
  - State goes to IDLE.
  - All outputs are 0. Phase, capture register, reference register and match count are 0.
- **IDLE:** if `iE`=1, go to SEEK.
- **SEEK:**
  - First sample with `iPULSE`=0 defines phase 0. Set capture = `1<<0` and go to TRACK with phase=1.
  - If LEN consecutive samples have `iPULSE`=1:
    - Set `oMASK`=0, pulse `oVALID`, go to LOCK, phase=0.
    - This is the no-skip pattern.
- **TRACK:**
  - Each cycle, capture[phase] = ~`iPULSE`.
  - At phase LEN-1, the period is complete:
    - First period: reference ← capture, match=1.
    - Later period equal to reference: match+1.
    - Later period different from reference: reference ← capture, match=1.
  - When match reaches CONFIRM:
    - `oMASK` ← reference, `oVALID`=1 for one cycle.
    - Go to LOCK, with phase wrapping to 0.
- **LOCK:**
  - Each cycle, compare ~`iPULSE` with `oMASK`[phase].
  - On mismatch:
    - `oERR`=1 for one cycle and `oLOCK` drops.
    - Go to SEEK. The mismatching sample is discarded and is not used as the new alignment.
    - `oMASK` holds its last value.
- **`iE`=0 in any state:** go to IDLE next cycle, `oLOCK`=0, `oMASK`/`oSKIPS` hold. Takes precedence over all other transitions.
- **`oSKIPS`:** recomputed from `oMASK` and registered with it.

## Timing
- **`oLOCK` latency:** first skip sampled at cycle t0 gives `oLOCK`=1 and `oVALID`=1 at t0 + CONFIRM·LEN.
- **No-skip lock:** `oLOCK` asserts LEN cycles after SEEK is entered.
- **`oERR`:** registered. Visible the cycle after the mismatching sample. `oLOCK`=0 in that same cycle.
- **Simultaneous events:**
  - Reset dominates `iE`.
  - `iE`=0 dominates mismatch and lock completion: no `oERR`, no `oVALID`.
- **Reset mid-TRACK:** partial capture is discarded. Lock restarts from SEEK.

## Configuration
- **`SKIPDECODE_ERRCNT_EN` defined:**
  - `oERRCNT` increments on every `oERR` and saturates at 255.
  - Cleared only by reset.
- **Undefined:** `oERRCNT` is tied to 0 and no counter logic is built.

## Structure
- **Package `skip_pkg`:**
  - State encoding (IDLE/SEEK/TRACK/LOCK).
  - Default `LEN` and `CONFIRM`.
  - Width constants for the phase counter and `oSKIPS`.
  - Width of `oERRCNT`.
  - Shared with the skip ring.
- **Sub-module `skipphase`:** phase counter with synchronous clear-to-value, enable and wrap strobe. Instantiated once.

## Test plan
- **Basic lock:** `LEN`=16, `CONFIRM`=2, skips at ring positions 3 and 5 repeating every 16 cycles → `oMASK`=16'h0005, `oSKIPS`=2, `oLOCK`/`oVALID` high 32 cycles after first skip.
- **Mismatch while locked:** locked on 16'h0005, one extra skip at phase 8 → `oERR` single-cycle pulse, `oLOCK`=0 next cycle, `oMASK` held, relock 32 cycles after the next skip.
- **No skips:** `iPULSE` held at 1 after enable → `oLOCK`=1 and `oMASK`=0 after 16 cycles. A later single skip → `oERR`.
- **Unstable pattern:** periods alternating between 16'h0003 and 16'h0005 → never locks, `oVALID` stays 0.
- **Reset and enable:**
  - `iRSTN` low at phase 7 of TRACK → all outputs 0 next cycle.
  - `iE` low while locked → `oLOCK`=0, no `oERR`.
- **Error counter, with `SKIPDECODE_ERRCNT_EN`:** 300 forced mismatch/relock sequences → `oERRCNT` saturates at 255.

Source files
------------

// File: rtl/skip_pkg.sv
// skip_pkg: state encoding, default geometry and width helpers shared by the skip ring and skipdecode
package skip_pkg;
  typedef enum logic [1:0] {IDLE, SEEK, TRACK, LOCK} state_t;
  localparam int DEF_LEN = 16;
  localparam int DEF_CONFIRM = 2;
  localparam int ERRCNT_W = 8;
  function automatic int ph_w(input int len);
    return $clog2(len);
  endfunction
  function automatic int sk_w(input int len);
    return $clog2(len + 1);
  endfunction
  localparam int PH_W = ph_w(DEF_LEN);
  localparam int SK_W = sk_w(DEF_LEN);
endpackage

// File: rtl/skipdecode_if.sv
// skipdecode_if: decoder enable and pulse sample inputs, learned-mask status outputs
interface skipdecode_if import skip_pkg::*; #(
  parameter int LEN = DEF_LEN
) ();
  logic iE;
  logic iPULSE;
  logic [LEN-1:0] oMASK;
  logic oLOCK;
  logic oVALID;
  logic oERR;
  logic [sk_w(LEN)-1:0] oSKIPS;
  logic [ERRCNT_W-1:0] oERRCNT;
  modport master (output iE, iPULSE, input oMASK, oLOCK, oVALID, oERR, oSKIPS, oERRCNT);
  modport slave (input iE, iPULSE, output oMASK, oLOCK, oVALID, oERR, oSKIPS, oERRCNT);
endinterface

// File: rtl/skipphase.sv
// skipphase: ring phase counter with synchronous load-to-value, enable and wrap strobe
module skipphase import skip_pkg::*; #(
  parameter int LEN = DEF_LEN,
  parameter int PW = ph_w(LEN)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic [PW-1:0] clr_val,
  input  logic en,
  output logic [PW-1:0] phase,
  output logic wrap
);
  logic [PW-1:0] phase_q, phase_d;
  always_comb begin
    wrap = en && phase_q == PW'(LEN - 1);
    phase_d = clr ? clr_val : wrap ? '0 : en ? phase_q + 1'b1 : phase_q;
  end
  always_ff @(posedge clk)
    if (!rstn) phase_q <= '0;
    else phase_q <= phase_d;
  assign phase = phase_q;
endmodule

// File: rtl/skipdecode.sv
// skipdecode: learns the periodic clock-skip mask (bit 0 = first skip seen), locks to it and flags departures.
// Define SKIPDECODE_ERRCNT_EN to build the saturating mismatch counter behind oERRCNT.
module skipdecode import skip_pkg::*; #(
  parameter int LEN = DEF_LEN,
  parameter int CONFIRM = DEF_CONFIRM
) (
  input logic iCLK,
  input logic iRSTN,
  skipdecode_if.slave bus
);
  localparam int PW = ph_w(LEN);
  localparam int SW = sk_w(LEN);
  localparam int MW = $clog2(CONFIRM + 1);
  state_t state_q, state_d;
  logic [LEN-1:0] cap_q, cap_d, ref_q, ref_d, mask_q, mask_d, cap_w;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] skips_q, skips_d;
  logic valid_q, valid_d, err_q, err_d;
  logic clr, en, wrap, skip, hit;
  logic [PW-1:0] clr_val, phase;

  skipphase #(.LEN(LEN), .PW(PW)) u_phase (
    .clk(iCLK), .rstn(iRSTN), .clr(clr), .clr_val(clr_val), .en(en), .phase(phase), .wrap(wrap)
  );

  // cap_w is the period including the current sample, so a period is judged on its last cycle
  always_comb begin
    skip = ~bus.iPULSE;
    cap_w = cap_q;
    cap_w[phase] = skip;
    hit = match_q != '0 && cap_w == ref_q;
    state_d = state_q;
    cap_d = cap_q;
    ref_d = ref_q;
    match_d = match_q;
    mask_d = mask_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    clr = 1'b0;
    clr_val = '0;
    en = 1'b0;
    if (!bus.iE) begin
      state_d = IDLE;
      clr = 1'b1;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (skip) begin
            cap_d = LEN'(1);
            match_d = '0;
            clr = 1'b1;
            clr_val = PW'(1);
            state_d = TRACK;
          end else begin
            en = 1'b1;
            if (wrap) begin
              mask_d = '0;
              valid_d = 1'b1;
              state_d = LOCK;
            end
          end
        end
        TRACK: begin
          en = 1'b1;
          cap_d = cap_w;
          if (wrap) begin
            ref_d = cap_w;
            match_d = hit ? match_q + 1'b1 : MW'(1);
            if (hit && match_d == MW'(CONFIRM)) begin
              mask_d = cap_w;
              valid_d = 1'b1;
              state_d = LOCK;
            end
          end
        end
        LOCK: begin
          if (skip != mask_q[phase]) begin
            err_d = 1'b1;
            clr = 1'b1;
            state_d = SEEK;
          end else en = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    skips_d = SW'($countones(mask_d));
  end

  always_ff @(posedge iCLK)
    if (!iRSTN) begin
      state_q <= IDLE;
      cap_q <= '0;
      ref_q <= '0;
      match_q <= '0;
      mask_q <= '0;
      skips_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      ref_q <= ref_d;
      match_q <= match_d;
      mask_q <= mask_d;
      skips_q <= skips_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end

  assign bus.oMASK = mask_q;
  assign bus.oLOCK = state_q == LOCK;
  assign bus.oVALID = valid_q;
  assign bus.oERR = err_q;
  assign bus.oSKIPS = skips_q;

`ifdef SKIPDECODE_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  assign errcnt_d = errcnt_q + ERRCNT_W'(err_d && errcnt_q != '1);
  always_ff @(posedge iCLK)
    if (!iRSTN) errcnt_q <= '0;
    else errcnt_q <= errcnt_d;
  assign bus.oERRCNT = errcnt_q;
`else
  assign bus.oERRCNT = '0;
`endif
endmodule

// File: tb/tb_skipdecode.sv
// tb_skipdecode: directed plan scenarios plus randomized periodic patterns against a sample-history model
module tb_skipdecode;
  import skip_pkg::*;
  localparam int LEN = DEF_LEN;
  localparam int CONFIRM = DEF_CONFIRM;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  skipdecode_if #(.LEN(LEN)) bus ();
  skipdecode #(.LEN(LEN), .CONFIRM(CONFIRM)) dut (.iCLK(clk), .iRSTN(rstn), .bus(bus));

  bit active, locked, m_valid, m_err;
  bit hist[$];
  int ones, pos, vseen, m_cnt;
  logic [PH_W-1:0] lph;
  logic [LEN-1:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // true when the history ends on CONFIRM identical whole periods
  function automatic bit stable();
    int n = hist.size();
    if (n % LEN != 0 || n < CONFIRM * LEN) return 1'b0;
    for (int k = 1; k < CONFIRM; k++)
      for (int i = 0; i < LEN; i++)
        if (hist[n - LEN + i] != hist[n - (k + 1) * LEN + i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic ref_step(input bit r, input bit e, input bit s);
    m_valid = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      active = 1'b0; locked = 1'b0; hist.delete(); ones = 0; m_mask = '0; m_cnt = 0;
    end else if (!e) begin
      active = 1'b0; locked = 1'b0; hist.delete(); ones = 0;
    end else if (!active) active = 1'b1;
    else if (locked) begin
      if (s != m_mask[lph]) begin
        m_err = 1'b1; locked = 1'b0;
        m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
      end
      lph = PH_W'((lph + 1) % LEN);
    end else if (hist.size() == 0) begin
      if (s) begin
        hist.push_back(1'b1); ones = 0;
      end else begin
        ones++;
        if (ones == LEN) begin
          m_mask = '0; locked = 1'b1; lph = '0; m_valid = 1'b1; ones = 0;
        end
      end
    end else begin
      hist.push_back(s);
      if (stable()) begin
        for (int i = 0; i < LEN; i++) m_mask[i] = hist[hist.size() - LEN + i];
        locked = 1'b1; lph = '0; m_valid = 1'b1; hist.delete();
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit p);
    rstn = r;
    bus.iE = e;
    bus.iPULSE = p;
    @(posedge clk);
    ref_step(r, e, !p);
    #1;
    vseen += int'(bus.oVALID);
    chk("mask", bus.oMASK, m_mask);
    chk("lock", bus.oLOCK, locked);
    chk("valid", bus.oVALID, m_valid);
    chk("err", bus.oERR, m_err);
    chk("skips", bus.oSKIPS, SK_W'($countones(m_mask)));
`ifdef SKIPDECODE_ERRCNT_EN
    chk("errcnt", bus.oERRCNT, m_cnt);
`else
    chk("errcnt", bus.oERRCNT, 0);
`endif
  endtask

  task automatic pat(input logic [LEN-1:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, !m[pos]);
      pos = (pos + 1) % LEN;
    end
  endtask

  initial begin
    logic [LEN-1:0] m;
    bit p;
    bus.iE = 1'b0;
    bus.iPULSE = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("rst_mask", bus.oMASK, 0);
    chk("rst_lock", bus.oLOCK, 0);
    cyc(1, 1, 1);
    pos = 0;
    pat(16'h0028, 34);
    chk("pre_lock", bus.oLOCK, 0);
    pat(16'h0028, 1);
    chk("lock_t0", bus.oLOCK, 1);
    chk("valid_t0", bus.oVALID, 1);
    chk("mask_05", bus.oMASK, 16'h0005);
    chk("skips_2", bus.oSKIPS, 2);
    pat(16'h0028, 1);
    chk("valid_once", bus.oVALID, 0);
    pat(16'h0028, 7);
    cyc(1, 1, 0);
    pos = (pos + 1) % LEN;
    chk("err_pulse", bus.oERR, 1);
    chk("err_unlock", bus.oLOCK, 0);
    chk("err_hold", bus.oMASK, 16'h0005);
    pat(16'h0028, 1);
    chk("err_once", bus.oERR, 0);
    pat(16'h0028, 37);
    chk("relock_pre", bus.oLOCK, 0);
    pat(16'h0028, 1);
    chk("relock", bus.oLOCK, 1);
    chk("relock_mask", bus.oMASK, 16'h0005);
    cyc(1, 0, 1);
    chk("e_noerr", bus.oERR, 0);
    chk("e_unlock", bus.oLOCK, 0);
    chk("e_hold", bus.oMASK, 16'h0005);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    repeat (LEN - 1) cyc(1, 1, 1);
    chk("noskip_pre", bus.oLOCK, 0);
    cyc(1, 1, 1);
    chk("noskip_lock", bus.oLOCK, 1);
    chk("noskip_mask", bus.oMASK, 0);
    chk("noskip_valid", bus.oVALID, 1);
    cyc(1, 1, 0);
    chk("noskip_err", bus.oERR, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    vseen = 0;
    pos = 0;
    for (int k = 0; k < 8; k++) pat(k % 2 ? 16'h0005 : 16'h0003, LEN);
    chk("unstable_valid", vseen, 0);
    chk("unstable_lock", bus.oLOCK, 0);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    pos = 0;
    pat(16'h0028, 35);
    chk("pre_rst_mask", bus.oMASK, 16'h0005);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    pos = 0;
    pat(16'h0028, 10);
    m = 16'h0028;
    cyc(0, 1, !m[10]);
    pos = 11;
    chk("midrst_mask", bus.oMASK, 0);
    chk("midrst_skips", bus.oSKIPS, 0);
    chk("midrst_lock", bus.oLOCK, 0);
    pat(16'h0028, 40);
    chk("rst_relock", bus.oLOCK, 1);
`ifdef SKIPDECODE_ERRCNT_EN
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    for (int k = 0; k < 300; k++) begin
      repeat (LEN) cyc(1, 1, 1);
      cyc(1, 1, 0);
    end
    chk("errcnt_sat", bus.oERRCNT, 255);
`endif
    for (int ep = 0; ep < 60; ep++) begin
      m = ($urandom_range(0, 4) == 0) ? '0 : LEN'($urandom) & LEN'($urandom);
      pos = $urandom_range(0, LEN - 1);
      repeat ($urandom_range(20, 90)) begin
        p = !m[pos];
        if ($urandom_range(0, 119) == 0) p = !p;
        cyc($urandom_range(0, 299) != 0, $urandom_range(0, 149) != 0, p);
        pos = (pos + 1) % LEN;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
